// File: rtl/snake_pkg.sv
// Shared constants, fruit type codes and the placement FSM state type for the snake game.
package snake_pkg;

    localparam int COORD_WIDTH  = 10;
    localparam int LENGTH_WIDTH = 6;
    localparam int GRID_W       = 64;
    localparam int GRID_H       = 48;
    localparam int BLOCK_SIZE   = 10;
    localparam int MAX_TRIES    = 10;

    localparam logic [1:0] FRUIT_GROW   = 2'b01;
    localparam logic [1:0] FRUIT_SHRINK = 2'b10;
    localparam logic [1:0] FRUIT_LIFE   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_SCAN,
        ST_COMMIT,
        ST_FAIL
    } place_state_t;

    // Type code 00 means "no fruit", so a raw draw of 00 becomes a grow fruit.
    function automatic logic [1:0] remap_type(input logic [1:0] raw);
        return (raw == 2'b00) ? FRUIT_GROW : raw;
    endfunction

endpackage

// File: rtl/fruit_candidate_map.sv
// Combinational mapping of an LFSR word to a candidate fruit cell in pixel coordinates.
module fruit_candidate_map #(
    parameter int COORD_WIDTH = snake_pkg::COORD_WIDTH,
    parameter int GRID_W      = snake_pkg::GRID_W,
    parameter int GRID_H      = snake_pkg::GRID_H,
    parameter int BLOCK_SIZE  = snake_pkg::BLOCK_SIZE
) (
    input  logic [15:0]            rnd,
    output logic [COORD_WIDTH-1:0] cand_x,
    output logic [COORD_WIDTH-1:0] cand_y,
    output logic [1:0]             cand_type
);
    import snake_pkg::*;

    localparam logic [6:0]             GW = 7'(GRID_W);
    localparam logic [7:0]             GH = 8'(GRID_H);
    localparam logic [COORD_WIDTH-1:0] BS = COORD_WIDTH'(BLOCK_SIZE);

    logic [6:0] x_cell;
    logic [7:0] y_cell;
    logic       unused_rnd_bits;

    always_comb begin
        x_cell    = {1'b0, rnd[5:0]} % GW;
        y_cell    = rnd[15:8] % GH;
        cand_x    = COORD_WIDTH'(x_cell) * BS;
        cand_y    = COORD_WIDTH'(y_cell) * BS;
        cand_type = remap_type(rnd[2:1]);
    end

    assign unused_rnd_bits = ^rnd[7:6];

endmodule

// File: rtl/fruit_placement_controller.sv
// Sequencer that draws fruit candidates and scans the snake body RAM for collisions before committing.
module fruit_placement_controller #(
    parameter int COORD_WIDTH  = snake_pkg::COORD_WIDTH,
    parameter int LENGTH_WIDTH = snake_pkg::LENGTH_WIDTH,
    parameter int GRID_W       = snake_pkg::GRID_W,
    parameter int GRID_H       = snake_pkg::GRID_H,
    parameter int BLOCK_SIZE   = snake_pkg::BLOCK_SIZE,
    parameter int MAX_TRIES    = snake_pkg::MAX_TRIES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    place_req,
    input  logic [15:0]             rnd,
    input  logic [LENGTH_WIDTH-1:0] snake_length,
    output logic [LENGTH_WIDTH-1:0] body_rd_addr,
    input  logic [COORD_WIDTH-1:0]  body_rd_x,
    input  logic [COORD_WIDTH-1:0]  body_rd_y,
    output logic [COORD_WIDTH-1:0]  fruit_x,
    output logic [COORD_WIDTH-1:0]  fruit_y,
    output logic [1:0]              fruit_type,
    output logic                    fruit_valid,
    output logic                    busy,
    output logic                    place_done,
    output logic                    place_fail
);
    import snake_pkg::*;

    localparam int TW = $clog2(MAX_TRIES) + 1;
    localparam logic [COORD_WIDTH-1:0] RESET_POS = COORD_WIDTH'(100);

    place_state_t state, state_next;

    logic [COORD_WIDTH-1:0]  map_x, map_y;
    logic [1:0]              map_type;
    logic [COORD_WIDTH-1:0]  cand_x, cand_y;
    logic [1:0]              cand_type;
    logic [LENGTH_WIDTH-1:0] len_q;
    logic [LENGTH_WIDTH-1:0] prev_addr;
    logic                    cmp_valid;
    logic [TW-1:0]           tries;
    logic [TW-1:0]           tries_inc;
    logic                    hit;
    logic                    last_seg;
    logic                    addr_at_end;

    fruit_candidate_map #(
        .COORD_WIDTH (COORD_WIDTH),
        .GRID_W      (GRID_W),
        .GRID_H      (GRID_H),
        .BLOCK_SIZE  (BLOCK_SIZE)
    ) u_map (
        .rnd       (rnd),
        .cand_x    (map_x),
        .cand_y    (map_y),
        .cand_type (map_type)
    );

    // Read data lags the address by one cycle, so compare against the previous address.
    always_comb begin
        tries_inc   = tries + 1'b1;
        addr_at_end = (body_rd_addr == len_q - 1'b1);
        hit         = cmp_valid && (body_rd_x == cand_x) && (body_rd_y == cand_y);
        last_seg    = cmp_valid && (prev_addr == len_q - 1'b1);
    end

    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        place_done = (state == ST_COMMIT);
        place_fail = (state == ST_FAIL);
        case (state)
            ST_IDLE:   if (place_req) state_next = ST_DRAW;
            ST_DRAW:   state_next = (snake_length == '0) ? ST_COMMIT : ST_SCAN;
            ST_SCAN: begin
                if (hit)
                    state_next = (tries_inc < TW'(MAX_TRIES)) ? ST_DRAW : ST_FAIL;
                else if (last_seg)
                    state_next = ST_COMMIT;
            end
            ST_COMMIT: state_next = ST_IDLE;
            ST_FAIL:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            fruit_x      <= RESET_POS;
            fruit_y      <= RESET_POS;
            fruit_type   <= FRUIT_GROW;
            fruit_valid  <= 1'b1;
            body_rd_addr <= '0;
            prev_addr    <= '0;
            cmp_valid    <= 1'b0;
            tries        <= '0;
            len_q        <= '0;
            cand_x       <= '0;
            cand_y       <= '0;
            cand_type    <= FRUIT_GROW;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (place_req) begin
                        fruit_valid <= 1'b0;
                        tries       <= '0;
                    end
                end
                ST_DRAW: begin
                    cand_x       <= map_x;
                    cand_y       <= map_y;
                    cand_type    <= map_type;
                    len_q        <= snake_length;
                    body_rd_addr <= '0;
                    cmp_valid    <= 1'b0;
                end
                ST_SCAN: begin
                    cmp_valid <= 1'b1;
                    prev_addr <= body_rd_addr;
                    if (!addr_at_end)
                        body_rd_addr <= body_rd_addr + 1'b1;
                    if (hit)
                        tries <= tries_inc;
                end
                ST_COMMIT: begin
                    fruit_x     <= cand_x;
                    fruit_y     <= cand_y;
                    fruit_type  <= cand_type;
                    fruit_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
